// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, code constants and key-map decode
// for the 4x4 keypad scanner (keypad_scan, keypad_row_sync, keypad_if).
package keypad_pkg;

    localparam int NUM_W = 5;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    localparam logic [NUM_W-1:0] NUM_NONE   = 5'd31;
    localparam logic [NUM_W-1:0] KEY_START  = 5'd10;
    localparam logic [NUM_W-1:0] KEY_CLEAR  = 5'd11;
    localparam logic [NUM_W-1:0] KEY_ENTER  = 5'd12;
    localparam logic [NUM_W-1:0] KEY_IGNORE = 5'd15;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        LOAD,
        HOLD,
        UNLOAD
    } kp_state_t;

    // True when exactly one line of an active-low group is low.
    function automatic logic one_low(input logic [3:0] v);
        return $countones(~v) == 1;
    endfunction

    // Index of the low line; only meaningful when one_low() holds.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_digit(input logic [NUM_W-1:0] code);
        return code <= 5'd9;
    endfunction

    // Rows r0..r3 x cols c0..c3:
    // 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [NUM_W-1:0] key_decode(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [NUM_W-1:0] code;
        case ({row, col})
            4'h0:    code = 5'd1;
            4'h1:    code = 5'd2;
            4'h2:    code = 5'd3;
            4'h3:    code = KEY_START;
            4'h4:    code = 5'd4;
            4'h5:    code = 5'd5;
            4'h6:    code = 5'd6;
            4'h7:    code = KEY_CLEAR;
            4'h8:    code = 5'd7;
            4'h9:    code = 5'd8;
            4'hA:    code = 5'd9;
            4'hB:    code = KEY_ENTER;
            4'hD:    code = 5'd0;
            default: code = KEY_IGNORE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: key-code bus from the keypad scanner to the charger controller.
// master drives num/start/clear/enter/startSet; slave samples them.
interface keypad_if;
    import keypad_pkg::*;

    logic [NUM_W-1:0] num;
    logic             start;
    logic             clear;
    logic             enter;
    logic             startSet;

    modport master (output num, start, clear, enter, startSet);
    modport slave  (input  num, start, clear, enter, startSet);

endinterface

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 2-FF synchroniser for the asynchronous keypad rows.
// Ports: CLK, nRST (sync, active-low), row_in[3:0] async, rs[3:0] synced.
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic [3:0] row_in,
    output logic [3:0] rs
);

    logic [3:0] meta_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            meta_q <= ROWS_IDLE;
            rs     <= ROWS_IDLE;
        end else begin
            meta_q <= row_in;
            rs     <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner, debouncer and decoder.
// Ports: CLK; nRST sync active-low; row_in[3:0] async rows;
// col_out[3:0] one-cold column drive; kif (master) key codes + startSet.
// Option KEYPAD_AUTOREPEAT_EN: held digits re-strobe startSet.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 25,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_TICKS   = 12500
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    keypad_if.master   kif
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

    if (SCAN_TICKS < 2) begin : g_bad_scan
        $error("SCAN_TICKS must be at least 2");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_deb
        $error("DEBOUNCE_SCANS must be at least 1");
    end
    if (REPEAT_TICKS < 2) begin : g_bad_rep
        $error("REPEAT_TICKS must be at least 2");
    end

    kp_state_t        state_q, state_n;
    logic [TW-1:0]    tick_q;
    logic [CW-1:0]    cnt_q, cnt_n, cnt_inc;
    logic [3:0]       col_q, col_n;
    logic [3:0]       pat_q, pat_n;
    logic [3:0]       rs;
    logic [NUM_W-1:0] key_q, key_n, scan_code;
    logic             sample, gap_n, code_on;

    logic [NUM_W-1:0] num_q;
    logic             start_q, clear_q, enter_q, ss_q;

    keypad_row_sync u_sync (
        .CLK    (CLK),
        .nRST   (nRST),
        .row_in (row_in),
        .rs     (rs)
    );

    assign sample    = (tick_q == TICK_LAST);
    assign cnt_inc   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;
    assign scan_code = key_decode(low_idx(rs), low_idx(col_q));
    assign code_on   = (state_n == LOAD) || (state_n == HOLD)
                    || (state_n == UNLOAD);

    always_comb begin
        state_n = state_q;
        col_n   = col_q;
        pat_n   = pat_q;
        key_n   = key_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            SCAN: begin
                if (sample) begin
                    if (one_low(rs) && scan_code != KEY_IGNORE) begin
                        pat_n   = rs;
                        key_n   = scan_code;
                        cnt_n   = CW'(1);
                        state_n = (DEBOUNCE_SCANS <= 1) ? LOAD : DEBOUNCE;
                    end else begin
                        col_n = {col_q[2:0], col_q[3]};
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (rs == pat_q) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CNT_DONE) state_n = LOAD;
                    end else begin
                        // Bounce: give up and move on to the next column.
                        state_n = SCAN;
                        col_n   = {col_q[2:0], col_q[3]};
                    end
                end
            end
            LOAD: begin
                state_n = HOLD;
                cnt_n   = '0;
            end
            HOLD: begin
                // Count consecutive all-high samples as release.
                if (sample) begin
                    if (rs == ROWS_IDLE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CNT_DONE) state_n = UNLOAD;
                    end else begin
                        cnt_n = '0;
                    end
                end
            end
            UNLOAD: begin
                state_n = SCAN;
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= SCAN;
            tick_q  <= '0;
            cnt_q   <= '0;
            col_q   <= COL_FIRST;
            pat_q   <= ROWS_IDLE;
            key_q   <= KEY_IGNORE;
        end else begin
            state_q <= state_n;
            tick_q  <= sample ? '0 : tick_q + 1'b1;
            cnt_q   <= cnt_n;
            col_q   <= col_n;
            pat_q   <= pat_n;
            key_q   <= key_n;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] rep_q;

    // One-cycle startSet gap; the counter restarts on each gap.
    assign gap_n = (state_q == HOLD) && (state_n == HOLD)
                && is_digit(key_q) && (rep_q == REP_LAST);

    always_ff @(posedge CLK) begin
        if (!nRST || gap_n || state_q != HOLD) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_q + 1'b1;
        end
    end
`else
    assign gap_n = 1'b0;
`endif

    // Outputs follow the next state so codes lead startSet by
    // one cycle on press and trail it by one cycle on release.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            num_q   <= NUM_NONE;
            start_q <= 1'b0;
            clear_q <= 1'b0;
            enter_q <= 1'b0;
            ss_q    <= 1'b0;
        end else begin
            if (code_on) begin
                num_q   <= is_digit(key_n) ? key_n : NUM_NONE;
                start_q <= (key_n == KEY_START);
                clear_q <= (key_n == KEY_CLEAR);
                enter_q <= (key_n == KEY_ENTER);
            end else begin
                num_q   <= NUM_NONE;
                start_q <= 1'b0;
                clear_q <= 1'b0;
                enter_q <= 1'b0;
            end
            ss_q <= (state_n == HOLD) && !gap_n;
        end
    end

    assign col_out      = col_q;
    assign kif.num      = num_q;
    assign kif.start    = start_q;
    assign kif.clear    = clear_q;
    assign kif.enter    = enter_q;
    assign kif.startSet = ss_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan with a keypad
// matrix model and a scoreboard of expected codes per startSet rise.
module tb_keypad_scan;

    localparam int ST = 4;
    localparam int DS = 3;
    localparam int RT = 40;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_GAPS = 2;
`else
    localparam int EXP_GAPS = 0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] down;

    keypad_if kif();

    keypad_scan #(
        .SCAN_TICKS     (ST),
        .DEBOUNCE_SCANS (DS),
        .REPEAT_TICKS   (RT)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .row_in  (row_in),
        .col_out (col_out),
        .kif     (kif)
    );

    always #5 CLK = ~CLK;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    int         vectors = 0;
    int         miscompares = 0;
    int         rises = 0;
    logic       mon_en = 1'b0;
    logic       ss_d = 1'b0;
    logic [7:0] codes_d = 8'h0;
    logic [7:0] codes;
    logic [7:0] sb[$];

    assign codes = {kif.num, kif.start, kif.clear, kif.enter};

    function automatic logic [7:0] code8(
        input logic [4:0] n, input logic s, input logic c, input logic e
    );
        return {n, s, c, e};
    endfunction

    task automatic check(
        input string tag, input logic [31:0] got, input logic [31:0] exp
    );
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ss(
        input logic lvl, input int budget, input string tag, output int n
    );
        n = 0;
        while (kif.startSet !== lvl && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(tag, kif.startSet, lvl);
    endtask

    // Scoreboard consumer: every startSet rise pops one expected code.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (kif.startSet && !ss_d) begin
                rises++;
                if (sb.size() == 0) check("extra_rise", 1, 0);
                else check("rise_code", codes, sb.pop_front());
                check("rise_settled", codes, codes_d);
            end
            if (!kif.startSet && ss_d) check("fall_held", codes, codes_d);
        end
        ss_d    = kif.startSet;
        codes_d = codes;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r0, gaps, bad;
        logic [3:0] seen;
        nRST = 1'b0;
        down = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_col", col_out, 4'b1110);
        check("rst_num", kif.num, 31);
        check("rst_flags", {kif.start, kif.clear, kif.enter}, 0);
        check("rst_ss", kif.startSet, 0);
        nRST = 1'b1;
        repeat (3) @(negedge CLK);
        check("col_slot0", col_out, 4'b1110);
        @(negedge CLK);
        check("col_step1", col_out, 4'b1101);
        repeat (ST) @(negedge CLK);
        check("col_step2", col_out, 4'b1011);
        repeat (ST) @(negedge CLK);
        check("col_step3", col_out, 4'b0111);
        repeat (ST) @(negedge CLK);
        check("col_wrap", col_out, 4'b1110);
        mon_en = 1'b1;

        // '7' = r2,c0
        sb.push_back(code8(5'd7, 0, 0, 0));
        down[8] = 1'b1;
        wait_ss(1, 200, "t2_rise", n);
        check("t2_col_frozen", col_out, 4'b1110);
        check("t2_num", kif.num, 7);
        repeat (20) @(negedge CLK);
        check("t2_col_still", col_out, 4'b1110);
        check("t2_ss_held", kif.startSet, 1);
        down[8] = 1'b0;
        wait_ss(0, 40, "t2_fall", n);
        check("t2_rel_min", n >= 11, 1);
        check("t2_rel_max", n <= 14, 1);
        check("t2_num_at_fall", kif.num, 7);
        @(negedge CLK);
        check("t2_num_idle", kif.num, 31);

        // A (r0,c3) bouncing on alternate samples
        r0 = rises;
        for (int i = 0; i < 16; i++) begin
            down[3] = ~down[3];
            repeat (ST) @(negedge CLK);
        end
        check("t3_bounce_rises", rises - r0, 0);
        check("t3_bounce_ss", kif.startSet, 0);
        sb.push_back(code8(5'd31, 1, 0, 0));
        down[3] = 1'b1;
        wait_ss(1, 200, "t3_rise", n);
        check("t3_start", kif.start, 1);
        check("t3_num", kif.num, 31);
        down[3] = 1'b0;
        wait_ss(0, 40, "t3_fall", n);
        @(negedge CLK);
        check("t3_start_idle", kif.start, 0);

        // A+B ghost pair on c3, then '*'
        r0 = rises;
        seen = '0;
        down[3] = 1'b1;
        down[7] = 1'b1;
        repeat (80) begin
            @(negedge CLK);
            seen = seen | ~col_out;
        end
        check("t4_ghost_rises", rises - r0, 0);
        check("t4_scan_moves", seen, 4'hF);
        down[3] = 1'b0;
        down[7] = 1'b0;
        down[12] = 1'b1;
        repeat (80) @(negedge CLK);
        check("t4_star_rises", rises - r0, 0);
        check("t4_star_ss", kif.startSet, 0);
        down[12] = 1'b0;
        repeat (10) @(negedge CLK);

        // '5' (r1,c1) then '3' (r0,c2) while held, then reset mid-HOLD
        r0 = rises;
        sb.push_back(code8(5'd5, 0, 0, 0));
        down[5] = 1'b1;
        wait_ss(1, 200, "t5_rise", n);
        down[2] = 1'b1;
        repeat (60) @(negedge CLK);
        check("t5_num_kept", kif.num, 5);
        check("t5_one_rise", rises - r0, 1);
        check("t5_ss_held", kif.startSet, 1);
        mon_en = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        check("t5_rst_ss", kif.startSet, 0);
        check("t5_rst_num", kif.num, 31);
        check("t5_rst_col", col_out, 4'b1110);
        nRST = 1'b1;
        sb.push_back(code8(5'd5, 0, 0, 0));
        @(negedge CLK);
        mon_en = 1'b1;
        wait_ss(1, 200, "t5_rereport", n);
        check("t5_re_num", kif.num, 5);
        down[5] = 1'b0;
        down[2] = 1'b0;
        wait_ss(0, 40, "t5_fall", n);

        // '2' (r0,c1) held: auto-repeat gaps only when enabled
        for (int i = 0; i <= EXP_GAPS; i++) sb.push_back(code8(5'd2, 0, 0, 0));
        down[1] = 1'b1;
        wait_ss(1, 200, "t6_rise", n);
        gaps = 0;
        bad = 0;
        repeat (100) begin
            @(negedge CLK);
            if (!kif.startSet) gaps++;
            if (kif.num != 5'd2) bad++;
        end
        check("t6_gaps", gaps, EXP_GAPS);
        check("t6_num_steady", bad, 0);
        down[1] = 1'b0;
        wait_ss(0, 40, "t6_fall", n);

        // C (r2,c3) held: never repeats
        sb.push_back(code8(5'd31, 0, 0, 1));
        down[11] = 1'b1;
        wait_ss(1, 200, "t6c_rise", n);
        gaps = 0;
        bad = 0;
        repeat (100) begin
            @(negedge CLK);
            if (!kif.startSet) gaps++;
            if (!kif.enter) bad++;
        end
        check("t6c_gaps", gaps, 0);
        check("t6c_enter", bad, 0);
        down[11] = 1'b0;
        wait_ss(0, 40, "t6c_fall", n);

        repeat (10) @(negedge CLK);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
